board_port_scheduler: RTL
=========================

# board_port_scheduler

Owns the single port of the board BRAM and decides each cycle who drives it: the renderer fetch, a pending cursor edit, or the life update engine. The renderer has absolute priority during active video. Blanking time, signalled by the renderer's `done_out`, is split as edit first, then generation step. The block also paces generations against frame count and pause, and counts generations.

## Interface
Parameters come from `common.svh`; the block has no local parameters.
- `WORD_SIZE`, `LOG_WORD_SIZE`, `BOARD_SIZE`, `LOG_MAX_ADDR`, `pos_t`.

Ports:
- `clk_130mhz` in 1: the only clock.
- `rst_n_in` in 1: reset, asynchronous and active-low.
- `render_done_in` in 1: renderer `done_out`; high means blanking.
- `render_addr_in` in LOG_MAX_ADDR: renderer read address.
- `upd_addr_in` in LOG_MAX_ADDR: updater address.
- `upd_we_in` in 1: updater write enable.
- `upd_wdata_in` in WORD_SIZE: updater write data.
- `upd_done_in` in 1: one-cycle pulse when a generation has been fully written.
- `upd_start_out` out 1: one-cycle pulse that begins a new generation.
- `upd_grant_out` out 1: updater owns the port; the updater must hold its state whenever this is low.
- `edit_req_in` in 1: pulse requesting a toggle of cell (`edit_x_in`, `edit_y_in`).
- `edit_x_in`, `edit_y_in` in pos_t: board coordinates of the cell to toggle.
- `edit_ack_out` out 1: pulse on the edit write-back cycle.
- `pause_in` in 1: blocks new generations; an already started generation still resumes.
- `frames_per_step_in` in 4: frames per generation; 0 is treated as 1.
- `mem_addr_out` out LOG_MAX_ADDR: BRAM address.
- `mem_we_out` out 1: BRAM write enable.
- `mem_wdata_out` out WORD_SIZE: BRAM write data.
- `mem_rdata_in` in WORD_SIZE: BRAM read data, 2-cycle read latency. It also feeds the renderer and updater directly; this block does not mux read data.
- `generation_out` out 16: completed-generation count; wraps.

## Operation
States:
- **IDLE** (reset state)
  - Port: render address, no write.
  - Exit: `render_done_in` falls → RENDER.
- **RENDER**
  - Port: render address, no write.
  - Exit, on `render_done_in` rising edge:
    - edit pending → EDIT_RD;
    - else update busy → STEP;
    - else step due → STEP, pulsing `upd_start_out` on entry;
    - else → IDLE.
- **EDIT_RD**
  - Port: edit address.
  - Next state: EDIT_W1.
- **EDIT_W1** → EDIT_W2 → EDIT_WR.
  - In EDIT_W2, capture `mem_rdata_in`.
- **EDIT_WR**
  - Port: edit address, `mem_we_out`=1.
  - Write data: captured word with bit `WORD_SIZE-1-x[LOG_WORD_SIZE-1:0]` inverted. This is MSB-first order, matching render fetch.
  - Pulse `edit_ack_out`; clear pending.
  - Next state: STEP or IDLE, using the same rule as RENDER exit.
- **STEP**
  - Port: `upd_*` signals pass through; `upd_grant_out`=1; busy flag set.
  - `upd_done_in` → IDLE; clear busy; `generation_out`+1.
  - `render_done_in` falls (higher priority than `upd_done_in` in the same cycle) → RENDER. Busy stays set; the next blank resumes without a new `upd_start_out`.

Edit address and pending rules:
- Edit address = `y*(BOARD_SIZE/WORD_SIZE) + (x >> LOG_WORD_SIZE)`, computed at latch time.
- `edit_req_in` latches x and y only when no edit is pending. Requests arriving while an edit is pending are dropped with no ack.
- If `render_done_in` falls during EDIT_RD, EDIT_W1 or EDIT_W2: abort to RENDER with no write; the edit stays pending.
- EDIT_WR always completes.

Step pacing:
- `frame_cnt` increments on each `render_done_in` rising edge and saturates at 15.
- Step due = `!pause_in && frame_cnt >= max(frames_per_step_in, 1)`.
- `frame_cnt` clears when `upd_start_out` pulses.

## Timing
- State and all counters are registered. Edge detection uses `done_q`, which resets to 1 so reset release gives no false rising edge.
- The first state-driven cycle follows the edge-detect cycle.
- Port outputs are a combinational mux on the registered state, so the render and update paths add zero latency. Edit address and data come from registers.
- Reset values:
  - state IDLE;
  - every output 0;
  - `frame_cnt`, `generation_out`, pending flag and busy flag all 0.
- Reset is asynchronous. Asserting it mid-edit or mid-step discards the operation immediately.
- Edit takes 4 cycles, from EDIT_RD through EDIT_WR.

## Structure
- Add to `common.svh`:
  - `sched_state_t` enum;
  - `WORDS_PER_ROW = BOARD_SIZE/WORD_SIZE`.
- One natural sub-module, `edit_rmw`: owns the latch, address calculation and bit toggle. It takes a start input and drives `done` / `we` outputs.

## Test plan
- **Reset release.** Hold `render_done_in`=1 through reset release. Expect IDLE, all outputs 0, and no `upd_start_out` pulse.
- **Edit.** Pre-load word `8'h00`. Request edit x=3, y=0 (`WORD_SIZE`=8) during active video. On the blank edge:
  - `mem_addr_out`=0;
  - 4 cycles later `mem_we_out`=1 with `mem_wdata_out`=`8'h10`;
  - `edit_ack_out` pulses once.
- **Pacing.** Set `frames_per_step_in`=2 and model `upd_done_in` 100 cycles after `upd_start_out`. Expect `upd_start_out` every 2nd blank and `generation_out` incrementing 1, 2, 3.
- **Preemption.** Drop `render_done_in` while in STEP. Expect:
  - that cycle `upd_grant_out`=1 and `mem_addr_out`=`upd_addr_in`;
  - next cycle `upd_grant_out`=0 and `mem_addr_out`=`render_addr_in`;
  - next blank, grant returns with no `upd_start_out`.
- **Simultaneous events.** Assert `upd_done_in` and drop `render_done_in` together. Expect RENDER with busy still set and `generation_out` unchanged.
- **Abort and drop.**
  - Drop `render_done_in` in EDIT_W1: no write, and the edit completes on the next blank.
  - Issue a second `edit_req_in` while the first is pending: it is dropped, giving exactly 1 ack.
  - Set `pause_in`=1: no `upd_start_out`.

Source files
------------

// File: rtl/board_port_scheduler_pkg.sv
// Shared board geometry, scheduler state encoding and pacing helper for the
// board BRAM port scheduler.
package board_port_scheduler_pkg;

    localparam int WORD_SIZE      = 8;
    localparam int LOG_WORD_SIZE  = 3;
    localparam int BOARD_SIZE     = 32;
    localparam int LOG_BOARD_SIZE = 5;
    localparam int WORDS_PER_ROW  = BOARD_SIZE / WORD_SIZE;
    localparam int LOG_MAX_ADDR   = 7;

    typedef logic [LOG_BOARD_SIZE-1:0] pos_t;

    typedef enum logic [2:0] {
        IDLE,
        RENDER,
        EDIT_RD,
        EDIT_W1,
        EDIT_W2,
        EDIT_WR,
        STEP
    } sched_state_t;

    // A programmed pace of zero frames behaves like one frame per generation.
    function automatic logic [3:0] frames_needed(input logic [3:0] fps);
        return (fps == 4'd0) ? 4'd1 : fps;
    endfunction

endpackage

// File: rtl/board_port_scheduler_if.sv
// Bundles the renderer, updater, cursor-edit, pacing and BRAM signals that the
// scheduler arbitrates between.
interface board_port_scheduler_if;
    import board_port_scheduler_pkg::*;

    logic                     render_done_in;
    logic [LOG_MAX_ADDR-1:0]  render_addr_in;
    logic [LOG_MAX_ADDR-1:0]  upd_addr_in;
    logic                     upd_we_in;
    logic [WORD_SIZE-1:0]     upd_wdata_in;
    logic                     upd_done_in;
    logic                     upd_start_out;
    logic                     upd_grant_out;
    logic                     edit_req_in;
    pos_t                     edit_x_in;
    pos_t                     edit_y_in;
    logic                     edit_ack_out;
    logic                     pause_in;
    logic [3:0]               frames_per_step_in;
    logic [LOG_MAX_ADDR-1:0]  mem_addr_out;
    logic                     mem_we_out;
    logic [WORD_SIZE-1:0]     mem_wdata_out;
    logic [WORD_SIZE-1:0]     mem_rdata_in;
    logic [15:0]              generation_out;

    modport slave (
        input  render_done_in, render_addr_in,
        input  upd_addr_in, upd_we_in, upd_wdata_in, upd_done_in,
        output upd_start_out, upd_grant_out,
        input  edit_req_in, edit_x_in, edit_y_in,
        output edit_ack_out,
        input  pause_in, frames_per_step_in,
        output mem_addr_out, mem_we_out, mem_wdata_out,
        input  mem_rdata_in,
        output generation_out
    );

    modport master (
        output render_done_in, render_addr_in,
        output upd_addr_in, upd_we_in, upd_wdata_in, upd_done_in,
        input  upd_start_out, upd_grant_out,
        output edit_req_in, edit_x_in, edit_y_in,
        input  edit_ack_out,
        output pause_in, frames_per_step_in,
        input  mem_addr_out, mem_we_out, mem_wdata_out,
        output mem_rdata_in,
        input  generation_out
    );

endinterface

// File: rtl/board_port_scheduler_edit_rmw.sv
// Cursor-edit read-modify-write helper: latches one pending cell toggle and
// builds the write-back word from the BRAM read data.
module edit_rmw
    import board_port_scheduler_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  pos_t                    x,
    input  pos_t                    y,
    input  logic                    start,
    input  logic                    capture,
    input  logic                    commit,
    input  logic [WORD_SIZE-1:0]    rdata,
    output logic                    pending,
    output logic [LOG_MAX_ADDR-1:0] addr,
    output logic [WORD_SIZE-1:0]    wdata,
    output logic                    we,
    output logic                    done
);

    localparam logic [WORD_SIZE-1:0] MSB_MASK = {1'b1, {(WORD_SIZE-1){1'b0}}};

    logic [LOG_MAX_ADDR-1:0]  addr_calc;
    logic [LOG_WORD_SIZE-1:0] bit_q;

    assign addr_calc = LOG_MAX_ADDR'(y) * LOG_MAX_ADDR'(WORDS_PER_ROW)
                     + LOG_MAX_ADDR'(x >> LOG_WORD_SIZE);

    // Only one edit is held at a time; later requests are dropped until write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            addr    <= '0;
            bit_q   <= '0;
        end else if (req && !pending) begin
            pending <= 1'b1;
            addr    <= addr_calc;
            bit_q   <= x[LOG_WORD_SIZE-1:0];
        end else if (commit) begin
            pending <= 1'b0;
        end
    end

    // Column 0 sits in the word MSB, the same order the renderer shifts out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdata <= '0;
        end else if (start) begin
            wdata <= '0;
        end else if (capture) begin
            wdata <= rdata ^ (MSB_MASK >> bit_q);
        end
    end

    assign we   = commit;
    assign done = commit;

endmodule

// File: rtl/board_port_scheduler.sv
// Single-port BRAM arbiter: renderer during active video, then a pending cursor
// edit, then a paced life-generation step during blanking.
module board_port_scheduler
    import board_port_scheduler_pkg::*;
(
    input  logic                   clk_130mhz,
    input  logic                   rst_n_in,
    board_port_scheduler_if.slave  bus
);

    sched_state_t            state;
    sched_state_t            state_next;
    logic                    done_q;
    logic                    rise;
    logic                    fall;
    logic [3:0]              frame_cnt;
    logic [3:0]              frame_next;
    logic                    step_due;
    logic                    start_set;
    logic                    start_q;
    logic                    busy;
    logic [15:0]             gen_cnt;
    logic                    edit_pending;
    logic [LOG_MAX_ADDR-1:0] edit_addr;
    logic [WORD_SIZE-1:0]    edit_wdata;
    logic                    edit_we;
    logic                    edit_done;

    assign rise = bus.render_done_in & ~done_q;
    assign fall = ~bus.render_done_in & done_q;

    // The blank that is just starting already counts toward the step pace.
    assign frame_next = (rise && frame_cnt != 4'd15) ? frame_cnt + 4'd1 : frame_cnt;
    assign step_due   = !bus.pause_in && (frame_next >= frames_needed(bus.frames_per_step_in));

    edit_rmw u_edit (
        .clk     (clk_130mhz),
        .rst_n   (rst_n_in),
        .req     (bus.edit_req_in),
        .x       (bus.edit_x_in),
        .y       (bus.edit_y_in),
        .start   (state == EDIT_RD),
        .capture (state == EDIT_W2),
        .commit  (state == EDIT_WR),
        .rdata   (bus.mem_rdata_in),
        .pending (edit_pending),
        .addr    (edit_addr),
        .wdata   (edit_wdata),
        .we      (edit_we),
        .done    (edit_done)
    );

    always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_set  = 1'b0;
        case (state)
            IDLE:    if (fall) state_next = RENDER;
            RENDER: begin
                if (rise) begin
                    if (edit_pending)  state_next = EDIT_RD;
                    else if (busy)     state_next = STEP;
                    else if (step_due) begin
                        state_next = STEP;
                        start_set  = 1'b1;
                    end else           state_next = IDLE;
                end
            end
            EDIT_RD: state_next = fall ? RENDER : EDIT_W1;
            EDIT_W1: state_next = fall ? RENDER : EDIT_W2;
            EDIT_W2: state_next = fall ? RENDER : EDIT_WR;
            // The write itself is never cut short; only the follow-on yields to video.
            EDIT_WR: begin
                if (fall)          state_next = RENDER;
                else if (busy)     state_next = STEP;
                else if (step_due) begin
                    state_next = STEP;
                    start_set  = 1'b1;
                end else           state_next = IDLE;
            end
            STEP: begin
                if (fall)                 state_next = RENDER;
                else if (bus.upd_done_in) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_addr_out  = bus.render_addr_in;
        bus.mem_we_out    = 1'b0;
        bus.mem_wdata_out = '0;
        bus.upd_grant_out = 1'b0;
        case (state)
            EDIT_RD, EDIT_W1, EDIT_W2: bus.mem_addr_out = edit_addr;
            EDIT_WR: begin
                bus.mem_addr_out  = edit_addr;
                bus.mem_we_out    = edit_we;
                bus.mem_wdata_out = edit_wdata;
            end
            STEP: begin
                bus.mem_addr_out  = bus.upd_addr_in;
                bus.mem_we_out    = bus.upd_we_in;
                bus.mem_wdata_out = bus.upd_wdata_in;
                bus.upd_grant_out = 1'b1;
            end
            default: ;
        endcase
    end

    // A preempted generation keeps busy set so the next blank resumes it without a restart.
    always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            done_q    <= 1'b1;
            start_q   <= 1'b0;
            frame_cnt <= '0;
            busy      <= 1'b0;
            gen_cnt   <= '0;
        end else begin
            done_q    <= bus.render_done_in;
            start_q   <= start_set;
            frame_cnt <= start_set ? 4'd0 : frame_next;
            if (state == STEP) begin
                busy <= fall | ~bus.upd_done_in;
                if (!fall && bus.upd_done_in) gen_cnt <= gen_cnt + 16'd1;
            end
        end
    end

    assign bus.upd_start_out  = start_q;
    assign bus.edit_ack_out   = edit_done;
    assign bus.generation_out = gen_cnt;

endmodule
